bbus_arbiter: RTL

BBUS_ARBITER -- requirements
Module: bbus_arbiter

---
 rtl/bbus_pkg.sv | 33 +++
 rtl/bbus_arbiter_if.sv | 40 ++++
 rtl/bbus_rr_pick.sv | 20 ++
 rtl/bbus_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bbus_pkg.sv
// Shared widths, FSM state encoding and request bundle for the bbus arbiter.
package bbus_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic bus_req_t pack_req(input logic              wr,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
    bus_req_t r;
    r.wr    = wr;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/bbus_arbiter_if.sv
// Requester and register-bus signals of the arbiter; master is the arbiter's view.
interface bbus_arbiter_if;
  import bbus_pkg::*;

  logic              m0_req;
  logic              m1_req;
  logic              m0_wr;
  logic              m1_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_ack;
  logic              m1_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] baddr;
  logic [DATA_W-1:0] bwrdata;
  logic              bwr;
  logic              bstrobe;
  logic [DATA_W-1:0] brddata;
  logic              busy;
  logic              gnt_id;

  modport master (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  brddata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata,
    output baddr, bwrdata, bwr, bstrobe, busy, gnt_id
  );

  modport slave (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output brddata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata,
    input  baddr, bwrdata, bwr, bstrobe, busy, gnt_id
  );

endinterface

// File: rtl/bbus_rr_pick.sv
// Two-way round-robin winner: on a tie the requester not granted last wins.
module bbus_rr_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic pick_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    pick_o  = 1'b0;
    if (req0_i && req1_i) begin
      pick_o = ~last_i;
    end else if (req1_i) begin
      pick_o = 1'b1;
    end
  end

endmodule

// File: rtl/bbus_arbiter.sv
// Two-requester register-bus arbiter: IDLE/ISSUE/WAIT/DONE, every output registered.
module bbus_arbiter
  import bbus_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input logic            clk,
  input logic            reset,
  bbus_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_q, gnt_d;
  logic              strobe_q, strobe_d;
  logic              bwr_q, bwr_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [DATA_W-1:0] bwrdata_q, bwrdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;

  logic              pick_valid;
  logic              pick;
  bus_req_t          sel_req;

  bbus_rr_pick u_pick (
    .req0_i  (bus.m0_req),
    .req1_i  (bus.m1_req),
    .last_i  (last_gnt_q),
    .valid_o (pick_valid),
    .pick_o  (pick)
  );

  always_comb begin
    if (pick) begin
      sel_req = pack_req(bus.m1_wr, bus.m1_addr, bus.m1_wdata);
    end else begin
      sel_req = pack_req(bus.m0_wr, bus.m0_addr, bus.m0_wdata);
    end
  end

  // Outputs are computed one cycle ahead from the next state so they leave flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    strobe_d   = 1'b0;
    bwr_d      = bwr_q;
    baddr_d    = baddr_q;
    bwrdata_d  = bwrdata_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          bwr_d      = sel_req.wr;
          baddr_d    = sel_req.addr;
          bwrdata_d  = sel_req.wdata;
          gnt_d      = pick;
          last_gnt_d = pick;
          strobe_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = WAIT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (!bwr_q) begin
            if (gnt_q) begin
              rdata1_d = bus.brddata;
            end else begin
              rdata0_d = bus.brddata;
            end
          end
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      strobe_q   <= 1'b0;
      bwr_q      <= 1'b0;
      baddr_q    <= '0;
      bwrdata_q  <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      strobe_q   <= strobe_d;
      bwr_q      <= bwr_d;
      baddr_q    <= baddr_d;
      bwrdata_q  <= bwrdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.bstrobe  = strobe_q;
  assign bus.bwr      = bwr_q;
  assign bus.baddr    = baddr_q;
  assign bus.bwrdata  = bwrdata_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.busy     = busy_q;
  assign bus.gnt_id   = gnt_q;

endmodule
